// File: rtl/layer_sched_pkg.sv
// rtl/layer_sched_pkg.sv - shared types and defaults for the layer priority scheduler
//
// Holds the layer-index type, the config FSM state encoding and the
// default/maximum layer counts used by the top and the priority encoder.
package layer_sched_pkg;

    localparam int NUM_LAYERS_DEFAULT = 8;
    localparam int MAX_LAYERS         = 8;

    typedef logic [2:0] layer_idx_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PENDING,
        ST_APPLY
    } sched_state_t;

endpackage

// File: rtl/layer_priority_encoder.sv
// rtl/layer_priority_encoder.sv - combinational masked priority search over the active table
//
// Ports:
//   table_flat : active table, slot s in bits [3s+2:3s]; slot 0 is highest priority
//   dr_eff     : per-layer drawing request after blink masking
//   hit        : some slot points at a requesting layer
//   layer      : layer index held by the lowest such slot (0 when no hit)
module layer_priority_encoder
    import layer_sched_pkg::*;
#(
    parameter int NUM_LAYERS = NUM_LAYERS_DEFAULT
) (
    input  logic [3*NUM_LAYERS-1:0] table_flat,
    input  logic [NUM_LAYERS-1:0]   dr_eff,
    output logic                    hit,
    output layer_idx_t              layer
);

    logic [MAX_LAYERS-1:0] dr_ext;

    // Walk from the lowest priority slot upward so the last match written
    // is the lowest slot; duplicates therefore resolve to the lower slot.
    always_comb begin
        dr_ext = MAX_LAYERS'(dr_eff);
        hit    = 1'b0;
        layer  = '0;
        for (int s = NUM_LAYERS - 1; s >= 0; s--) begin
            if (dr_ext[table_flat[3*s +: 3]]) begin
                hit   = 1'b1;
                layer = table_flat[3*s +: 3];
            end
        end
    end

endmodule

// File: rtl/layer_priority_scheduler.sv
// rtl/layer_priority_scheduler.sv - per-pixel layer arbitration with frame-synchronous table updates and blinking
//
// Ports:
//   clk, resetN     : clock, asynchronous active-low reset
//   startOfFrame    : one-cycle pulse at the first pixel of a frame
//   layerDR         : per-layer drawing request
//   layerRGB        : packed per-layer colours, layer i in [8i+7:8i]
//   bgRGB           : background colour when no layer wins
//   blinkEn         : per-layer blink enable
//   cfgValid/Ready  : shadow-table write handshake
//   cfgSlot/Layer   : slot to write and layer index to store there
//   cfgCommit       : request to copy the shadow table into the active table
//   RGBOut          : registered pixel colour
//   winLayer        : registered winning layer (0 when none)
//   anyHit          : registered "some layer won"
module layer_priority_scheduler
    import layer_sched_pkg::*;
#(
    parameter int NUM_LAYERS   = NUM_LAYERS_DEFAULT,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic [NUM_LAYERS-1:0]   layerDR,
    input  logic [8*NUM_LAYERS-1:0] layerRGB,
    input  logic [7:0]              bgRGB,
    input  logic [NUM_LAYERS-1:0]   blinkEn,
    input  logic                    cfgValid,
    output logic                    cfgReady,
    input  logic [2:0]              cfgSlot,
    input  logic [2:0]              cfgLayer,
    input  logic                    cfgCommit,
    output logic [7:0]              RGBOut,
    output logic [2:0]              winLayer,
    output logic                    anyHit
);

    localparam logic [3:0] LAYER_LIMIT = 4'(NUM_LAYERS);
    localparam logic [7:0] FRAME_LAST  = 8'(BLINK_FRAMES - 1);
    localparam int         RGB_W       = 8 * MAX_LAYERS;

    sched_state_t state, state_nxt;

    layer_idx_t active_tbl [NUM_LAYERS];
    layer_idx_t shadow_tbl [NUM_LAYERS];

    logic                    cfg_wr;
    logic [7:0]              frameCnt;
    logic                    blinkPhase;
    logic [NUM_LAYERS-1:0]   dr_eff;
    logic [3*NUM_LAYERS-1:0] table_flat;
    logic                    enc_hit;
    layer_idx_t              enc_layer;
    logic [RGB_W-1:0]        rgb_ext;

    // Config FSM: writes are only accepted in RUN, which also freezes the
    // shadow table while a commit waits for the frame boundary.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cfgReady  = 1'b0;
        case (state)
            ST_RUN: begin
                cfgReady = 1'b1;
                if (cfgCommit) begin
                    state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (startOfFrame) begin
                    state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Out-of-range slots or layers complete the handshake but store nothing.
    assign cfg_wr = cfgValid && cfgReady
                    && ({1'b0, cfgSlot}  < LAYER_LIMIT)
                    && ({1'b0, cfgLayer} < LAYER_LIMIT);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int s = 0; s < NUM_LAYERS; s++) begin
                active_tbl[s] <= layer_idx_t'(s);
                shadow_tbl[s] <= layer_idx_t'(s);
            end
        end else begin
            for (int s = 0; s < NUM_LAYERS; s++) begin
                if (cfg_wr && (cfgSlot == layer_idx_t'(s))) begin
                    shadow_tbl[s] <= cfgLayer;
                end
                if (state == ST_APPLY) begin
                    active_tbl[s] <= shadow_tbl[s];
                end
            end
        end
    end

    // Blink timing: phase starts visible and flips every BLINK_FRAMES frames.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frameCnt   <= '0;
            blinkPhase <= 1'b1;
        end else if (startOfFrame) begin
            if (frameCnt == FRAME_LAST) begin
                frameCnt   <= '0;
                blinkPhase <= ~blinkPhase;
            end else begin
                frameCnt <= frameCnt + 8'd1;
            end
        end
    end

    assign dr_eff = blinkPhase ? layerDR : (layerDR & ~blinkEn);

    always_comb begin
        table_flat = '0;
        for (int s = 0; s < NUM_LAYERS; s++) begin
            table_flat[3*s +: 3] = active_tbl[s];
        end
    end

    layer_priority_encoder #(
        .NUM_LAYERS(NUM_LAYERS)
    ) u_encoder (
        .table_flat(table_flat),
        .dr_eff    (dr_eff),
        .hit       (enc_hit),
        .layer     (enc_layer)
    );

    assign rgb_ext = RGB_W'(layerRGB);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            RGBOut   <= '0;
            winLayer <= '0;
            anyHit   <= 1'b0;
        end else if (enc_hit) begin
            RGBOut   <= rgb_ext[{enc_layer, 3'b000} +: 8];
            winLayer <= enc_layer;
            anyHit   <= 1'b1;
        end else begin
            RGBOut   <= bgRGB;
            winLayer <= '0;
            anyHit   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer_priority_scheduler.sv
// tb/tb_layer_priority_scheduler.sv - scoreboard bench for layer_priority_scheduler
module tb_layer_priority_scheduler;

    localparam int NL = 4;

    logic            clk = 1'b0;
    logic            resetN;
    logic            startOfFrame;
    logic [NL-1:0]   layerDR;
    logic [8*NL-1:0] layerRGB;
    logic [7:0]      bgRGB;
    logic [NL-1:0]   blinkEn;
    logic            cfgValid;
    logic            cfgReady;
    logic [2:0]      cfgSlot;
    logic [2:0]      cfgLayer;
    logic            cfgCommit;
    logic [7:0]      RGBOut;
    logic [2:0]      winLayer;
    logic            anyHit;

    layer_priority_scheduler #(
        .NUM_LAYERS  (NL),
        .BLINK_FRAMES(2)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .layerDR     (layerDR),
        .layerRGB    (layerRGB),
        .bgRGB       (bgRGB),
        .blinkEn     (blinkEn),
        .cfgValid    (cfgValid),
        .cfgReady    (cfgReady),
        .cfgSlot     (cfgSlot),
        .cfgLayer    (cfgLayer),
        .cfgCommit   (cfgCommit),
        .RGBOut      (RGBOut),
        .winLayer    (winLayer),
        .anyHit      (anyHit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] rgb;
        logic [2:0] win;
        logic       hit;
        logic       rdy;
        string      nm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation due in the cycle just completed.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: not observed, due cycle %0d now %0d", mon_e.nm, mon_e.cyc, cyc);
            end else if ({RGBOut, winLayer, anyHit, cfgReady} !==
                         {mon_e.rgb, mon_e.win, mon_e.hit, mon_e.rdy}) begin
                errors++;
                $display("FAIL %s: got rgb=%h win=%0d hit=%b rdy=%b, want rgb=%h win=%0d hit=%b rdy=%b",
                         mon_e.nm, RGBOut, winLayer, anyHit, cfgReady,
                         mon_e.rgb, mon_e.win, mon_e.hit, mon_e.rdy);
            end
        end
    end

    // Expect the given outputs after the next active edge, then advance one
    // cycle and drop the one-cycle pulses.
    task automatic step(input logic [7:0] rgb, input logic [2:0] win,
                        input logic hit, input logic rdy, input string nm);
        exp_t e;
        e.cyc = cyc + 1;
        e.rgb = rgb;
        e.win = win;
        e.hit = hit;
        e.rdy = rdy;
        e.nm  = nm;
        sb.push_back(e);
        @(negedge clk);
        startOfFrame = 1'b0;
        cfgValid     = 1'b0;
        cfgCommit    = 1'b0;
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        cfgValid     = 1'b0;
        cfgCommit    = 1'b0;
        cfgSlot      = 3'd0;
        cfgLayer     = 3'd0;
        layerDR      = '0;
        blinkEn      = '0;
        layerRGB     = {8'h77, 8'hE0, 8'h1C, 8'h03};
        bgRGB        = 8'h25;

        step(8'h00, 3'd0, 1'b0, 1'b1, "reset_state");

        resetN = 1'b1; layerDR = 4'b0110;
        step(8'h1C, 3'd1, 1'b1, 1'b1, "identity_order");
        layerDR = 4'b0001;
        step(8'h03, 3'd0, 1'b1, 1'b1, "layer0_win");
        layerDR = 4'b0000;
        step(8'h25, 3'd0, 1'b0, 1'b1, "background");

        // Blink, two frames per half-period
        blinkEn = 4'b0010; layerDR = 4'b0110;
        startOfFrame = 1'b1;
        step(8'h1C, 3'd1, 1'b1, 1'b1, "blink_sof1");
        startOfFrame = 1'b1;
        step(8'h1C, 3'd1, 1'b1, 1'b1, "blink_sof2");
        step(8'hE0, 3'd2, 1'b1, 1'b1, "blink_masked");
        layerDR = 4'b0010;
        step(8'h25, 3'd0, 1'b0, 1'b1, "blink_masked_bg");
        layerDR = 4'b0110; startOfFrame = 1'b1;
        step(8'hE0, 3'd2, 1'b1, 1'b1, "blink_sof3");
        startOfFrame = 1'b1;
        step(8'hE0, 3'd2, 1'b1, 1'b1, "blink_sof4");
        step(8'h1C, 3'd1, 1'b1, 1'b1, "blink_visible");
        blinkEn = 4'b0000;

        // Write + commit on the same edge; pending writes/commits are refused
        cfgValid = 1'b1; cfgSlot = 3'd0; cfgLayer = 3'd2; cfgCommit = 1'b1;
        step(8'h1C, 3'd1, 1'b1, 1'b0, "commit_accept");
        cfgValid = 1'b1; cfgSlot = 3'd0; cfgLayer = 3'd3; cfgCommit = 1'b1;
        step(8'h1C, 3'd1, 1'b1, 1'b0, "pending_hold");
        startOfFrame = 1'b1;
        step(8'h1C, 3'd1, 1'b1, 1'b0, "pending_sof");
        step(8'h1C, 3'd1, 1'b1, 1'b1, "apply_old_table");
        step(8'hE0, 3'd2, 1'b1, 1'b1, "new_table");
        step(8'hE0, 3'd2, 1'b1, 1'b1, "new_table_stable");

        // Reset while a commit is pending
        cfgValid = 1'b1; cfgSlot = 3'd0; cfgLayer = 3'd3; cfgCommit = 1'b1;
        step(8'hE0, 3'd2, 1'b1, 1'b0, "commit2_accept");
        #2 resetN = 1'b0;
        step(8'h00, 3'd0, 1'b0, 1'b1, "reset_in_pending");
        resetN = 1'b1;
        step(8'h1C, 3'd1, 1'b1, 1'b1, "identity_after_reset");
        startOfFrame = 1'b1;
        step(8'h1C, 3'd1, 1'b1, 1'b1, "reset_sof");
        step(8'h1C, 3'd1, 1'b1, 1'b1, "reset_no_apply1");
        step(8'h1C, 3'd1, 1'b1, 1'b1, "reset_no_apply2");

        // Out-of-range writes are accepted and dropped
        cfgValid = 1'b1; cfgSlot = 3'd7; cfgLayer = 3'd0;
        step(8'h1C, 3'd1, 1'b1, 1'b1, "slot7_accept");
        cfgValid = 1'b1; cfgSlot = 3'd0; cfgLayer = 3'd5;
        step(8'h1C, 3'd1, 1'b1, 1'b1, "layer5_accept");
        cfgCommit = 1'b1;
        step(8'h1C, 3'd1, 1'b1, 1'b0, "bnd_commit");
        startOfFrame = 1'b1;
        step(8'h1C, 3'd1, 1'b1, 1'b0, "bnd_sof");
        step(8'h1C, 3'd1, 1'b1, 1'b1, "bnd_apply");
        layerDR = 4'b0101;
        step(8'h03, 3'd0, 1'b1, 1'b1, "bnd_slot0_unchanged");
        layerDR = 4'b1000;
        step(8'h77, 3'd3, 1'b1, 1'b1, "bnd_slot3_unchanged");

        // Duplicate entries: slot0 = slot1 = 3
        layerDR = 4'b1110; cfgValid = 1'b1; cfgSlot = 3'd0; cfgLayer = 3'd3;
        step(8'h1C, 3'd1, 1'b1, 1'b1, "dup_write0");
        cfgValid = 1'b1; cfgSlot = 3'd1; cfgLayer = 3'd3; cfgCommit = 1'b1;
        step(8'h1C, 3'd1, 1'b1, 1'b0, "dup_commit");
        step(8'h1C, 3'd1, 1'b1, 1'b0, "dup_pending");
        startOfFrame = 1'b1;
        step(8'h1C, 3'd1, 1'b1, 1'b0, "dup_sof");
        step(8'h1C, 3'd1, 1'b1, 1'b1, "dup_apply");
        step(8'h77, 3'd3, 1'b1, 1'b1, "dup_layer3_wins");
        layerDR = 4'b0110;
        step(8'hE0, 3'd2, 1'b1, 1'b1, "dup_layer1_absent");
        layerDR = 4'b0011;
        step(8'h25, 3'd0, 1'b0, 1'b1, "dup_absent_bg");

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
